// File: rtl/excp_pkg.sv
// Shared types for the exception-tracking pipeline: error-vector bit indices,
// the per-stage record carried from fetch to memory, and the alignment helper.
package excp_pkg;

    localparam int EXC_RI     = 0;
    localparam int EXC_SYS    = 1;
    localparam int EXC_BP     = 2;
    localparam int EXC_ERET   = 3;
    localparam int EXC_ADES   = 4;
    localparam int EXC_ADEL_D = 5;
    localparam int EXC_ADEL_I = 6;
    localparam int EXC_OV     = 7;
    localparam int EXC_BD     = 9;
    localparam int EXC_MTC0   = 11;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [7:0]  flags;
        logic        bd;
        logic        mtc0;
        logic [31:0] badvaddr;
    } excp_rec_t;

    // Size encoding 3 is unused by the datapath and never reported as misaligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == 2'd1) && addr_lo[0]) || ((size == 2'd2) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/excp_stage_reg.sv
// One pipeline record register. Priority: reset > flush > stall (hold) >
// upstream bubble > load. Flushed and bubbled slots are fully zeroed.
module excp_stage_reg
    import excp_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      flush_i,
    input  logic      stall_i,
    input  logic      bubble_i,
    input  excp_rec_t rec_i,
    output excp_rec_t rec_o
);

    excp_rec_t rec_q;
    excp_rec_t rec_d;

    always_comb begin
        rec_d = rec_q;
        if (flush_i) begin
            rec_d = '0;
        end else if (stall_i) begin
            rec_d = rec_q;
        end else if (bubble_i) begin
            rec_d = '0;
        end else begin
            rec_d = rec_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign rec_o = rec_q;

endmodule

// File: rtl/excp_pipe.sv
// Exception-tracking pipeline F->D->E->M feeding CP0's error/BadVaddr/pcM.
// Define EXCP_ADDR_CHECK_EN to enable data-address alignment exceptions.
module excp_pipe
    import excp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    input  logic        validF,
    input  logic        stallD,
    input  logic        stallE,
    input  logic        stallM,
    input  logic        flush,
    input  logic        riD,
    input  logic        sysD,
    input  logic        bpD,
    input  logic        eretD,
    input  logic        mtc0D,
    input  logic        branchD,
    input  logic        ovE,
    input  logic        memrdE,
    input  logic        memwrE,
    input  logic [1:0]  sizeE,
    input  logic [31:0] addrE,
    output logic        memkillE,
    output logic [11:0] error,
    output logic [31:0] BadVaddr,
    output logic [31:0] pcM
);

    excp_rec_t fetch_rec, rec_fd, dec_rec, rec_de, exe_rec, rec_em;
    logic      stall_e, stall_d;
    logic      lastbr_q, lastbr_d;

    // A stage that cannot drain downstream must hold as well.
    assign stall_e = stallE | stallM;
    assign stall_d = stallD | stall_e;

    always_comb begin
        fetch_rec                   = '0;
        fetch_rec.valid             = validF;
        fetch_rec.pc                = pcF;
        fetch_rec.badvaddr          = pcF;
        fetch_rec.flags[EXC_ADEL_I] = validF & (pcF[1:0] != 2'b00);
    end

    excp_stage_reg u_fd (
        .clk(clk), .reset(reset), .flush_i(flush), .stall_i(stall_d),
        .bubble_i(1'b0), .rec_i(fetch_rec), .rec_o(rec_fd)
    );

    always_comb begin
        dec_rec      = rec_fd;
        dec_rec.bd   = rec_fd.valid & lastbr_q;
        dec_rec.mtc0 = rec_fd.valid & mtc0D;
        if (rec_fd.valid && !rec_fd.flags[EXC_ADEL_I]) begin
            dec_rec.flags[EXC_RI]   = riD;
            dec_rec.flags[EXC_SYS]  = sysD;
            dec_rec.flags[EXC_BP]   = bpD;
            dec_rec.flags[EXC_ERET] = eretD;
        end
    end

    always_comb begin
        lastbr_d = lastbr_q;
        if (flush) begin
            lastbr_d = 1'b0;
        end else if (rec_fd.valid && !stall_d) begin
            lastbr_d = branchD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lastbr_q <= 1'b0;
        end else begin
            lastbr_q <= lastbr_d;
        end
    end

    excp_stage_reg u_de (
        .clk(clk), .reset(reset), .flush_i(flush), .stall_i(stall_e),
        .bubble_i(stall_d), .rec_i(dec_rec), .rec_o(rec_de)
    );

`ifdef EXCP_ADDR_CHECK_EN
    logic addr_bad;
    assign addr_bad = misaligned(sizeE, addrE[1:0]);
`else
    logic unused_addr;
    assign unused_addr = ^{memrdE, memwrE, sizeE, addrE};
`endif

    // Only the oldest exception survives: overflow masks the address checks.
    always_comb begin
        exe_rec = rec_de;
        if (rec_de.valid && (rec_de.flags == 8'h00)) begin
            exe_rec.flags[EXC_OV] = ovE;
`ifdef EXCP_ADDR_CHECK_EN
            if (!ovE && addr_bad) begin
                exe_rec.flags[EXC_ADEL_D] = memrdE;
                exe_rec.flags[EXC_ADES]   = memwrE;
                if (memrdE || memwrE) begin
                    exe_rec.badvaddr = addrE;
                end
            end
`endif
        end
    end

    assign memkillE = exe_rec.valid & (|exe_rec.flags);

    excp_stage_reg u_em (
        .clk(clk), .reset(reset), .flush_i(flush), .stall_i(stallM),
        .bubble_i(stall_e), .rec_i(exe_rec), .rec_o(rec_em)
    );

    always_comb begin
        error = '0;
        if (rec_em.valid) begin
            error[7:0]      = rec_em.flags;
            error[EXC_BD]   = rec_em.bd;
            error[EXC_MTC0] = rec_em.mtc0 & ~(|rec_em.flags);
        end
    end

    assign pcM      = rec_em.pc;
    assign BadVaddr = rec_em.badvaddr;

endmodule

// File: doc/excp_pipe.md
# excp_pipe

Exception-tracking pipeline feeding the CP0 block. Carries per-instruction exception flags, the delay-slot bit, the faulting address and the PC from fetch through decode and execute into the memory stage. There it presents CP0's 12-bit `error` vector, `BadVaddr` and `pcM`. It also kills the data access of any excepting instruction and discards all in-flight state on CP0's `flush`.

## Interface
- No parameters.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `pcF` in 32: fetch PC.
- `validF` in 1: fetch slot holds a real instruction.
- `stallD`, `stallE`, `stallM` in 1 each: hold the D, E or M pipeline register respectively.
- `flush` in 1: exception/ERET redirect from CP0.
- `riD`, `sysD`, `bpD`, `eretD`, `mtc0D`, `branchD` in 1 each: decode results for the D instruction.
- `ovE` in 1: signed overflow of the E instruction.
- `memrdE`, `memwrE` in 1 each: E instruction loads/stores.
- `sizeE` in 2: 0 byte, 1 half, 2 word.
- `addrE` in 32: data virtual address.
- `memkillE` out 1: suppress the data access of the E instruction.
- `error` out 12: CP0 exception vector for the M instruction.
- `BadVaddr` out 32: faulting address for the M instruction.
- `pcM` out 32: PC of the M instruction.

## Operation
- Stage records F→D, D→E and E→M each hold: valid, pc, 8 exception flags, bd, mtc0, badvaddr.
- Error bit map:
  - [0] RI, [1] Sys, [2] Bp, [3] ERET.
  - [4] AdES (data store), [5] AdEL (data load), [6] AdEL (fetch), [7] Ov.
  - [9] BD, [11] MTC0 commit.
  - [8] and [10] are always 0.
- Fetch: flag [6] = `pcF[1:0]!=0`; badvaddr = `pcF`.
- Decode:
  - If the record already has [6], the decode flags are ignored.
  - Otherwise [0..3] come from `riD`/`sysD`/`bpD`/`eretD`.
  - bd = `lastbr`.
- `lastbr` register:
  - Set to `branchD` whenever a valid D record advances into E.
  - Cleared on flush/reset.
  - Unchanged while D holds or carries a bubble.
- Execute, only when the record has no earlier flag:
  - [7] = `ovE`.
  - misaligned = half with `addrE[0]`, or word with `addrE[1:0]!=0`.
  - [5] = `memrdE & misaligned`; [4] = `memwrE & misaligned`; on [4] or [5], badvaddr = `addrE`.
- `memkillE` = E record valid & (any flag [0..7] set after execute checks).
- Memory stage outputs:
  - `error[7:0]` = flags when M is valid, else 0.
  - `error[9]` = bd & valid.
  - `error[11]` = mtc0 & valid & no flag [0..7].
  - `pcM` and `BadVaddr` come straight from the M record.
- Stage advance priority, per register: reset > flush (valid←0) > stall (hold) > upstream stall (insert bubble, valid←0) > load.
- Bubbles carry all-zero flags; they never raise `error` or `memkillE`.

## Timing
- Unstalled latency: instruction with `pcF` at cycle t is visible on `pcM`/`error` at t+3.
- Outputs are combinational from the M register plus execute logic; there are no output registers.
- Reset values: every valid=0, `lastbr`=0, `error`=0, `BadVaddr`=0, `pcM`=0, `memkillE`=0.
- `flush` in cycle t: all records are invalid at t+1, so `error`=0 at t+1, even if stalls are asserted.
- Flush while `validF`=1: the fetch instruction is dropped.
- Stall in M with E free: E holds, since its record cannot enter M.
- Upstream stall rules are the caller's duty; stall signals must be monotone (`stallM`→`stallE`→`stallD`).
- Simultaneous fetch AdEL and decoded RI: only [6] reaches `error`.
- Simultaneous Ov and misaligned address: only [7] is set.

## Configuration
- `EXCP_ADDR_CHECK_EN` defined: data address checks as above.
- `EXCP_ADDR_CHECK_EN` undefined:
  - Flags [4]/[5] are tied 0.
  - badvaddr is written only by fetch.
  - `memkillE` ignores address alignment.

## Structure
- Shared package `excp_pkg`:
  - Bit-index constants EXC_RI=0, EXC_SYS=1, EXC_BP=2, EXC_ERET=3, EXC_ADES=4, EXC_ADEL_D=5, EXC_ADEL_I=6, EXC_OV=7, EXC_BD=9, EXC_MTC0=11.
  - Packed struct `excp_rec_t` (valid, pc, flags, bd, mtc0, badvaddr).
- Sub-module `excp_stage_reg`: one record register with reset/flush/stall/bubble priority; instantiated three times.

## Test plan
- `pcF`=0xbfc00002, no stalls → at t+3: `error`=0x040, `BadVaddr`=0xbfc00002, `pcM`=0xbfc00002.
- Branch at 0x100 followed by `sysD` at 0x104 → M shows 0x104 with `error`=0x202.
- Load word at `addrE`=0x80000006 → `memkillE`=1 that cycle; next cycle `error`=0x020, `BadVaddr`=0x80000006. With the macro undefined: `error`=0, `memkillE`=0.
- `mtc0D` together with `ovE` → `error`=0x080, bit 11 clear. `mtc0D` alone → `error`=0x800.
- `flush` with all stages valid and `stallM`=1 → next cycle `error`=0, `memkillE`=0, `lastbr`=0.
- `stallE` for 2 cycles with D flowing → M receives 2 bubbles, `error`=0; the held instruction exits with its flags intact.
